// File: rtl/ft2232h_tx_stream.sv
// FT2232H synchronous 245 FIFO write engine.
// A valid/ready word stream (or an internal 8-bit counter) is serialised LSB byte
// first onto D[7:0]/WR#. A byte counts as sent only on an edge where WR# was low
// and TXE# is low, so a burst interrupted by TXE# resumes without loss or repeats.
module ft2232h_tx_stream #(
  parameter int         DEPTH        = 16,
  parameter int         BYTES        = 1,
  parameter int         MODE         = 0,
  parameter logic [7:0] PATTERN_SEED = 8'd69
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     txe,
  input  logic [8*BYTES-1:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr,
  output logic [7:0]               data_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [31:0]              sent_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            IW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  // Bit 0 of the encoding is WR# itself, so the pin comes straight off a flop.
  typedef enum logic [1:0] {
    SEND = 2'b00,
    IDLE = 2'b01,
    HOLD = 2'b11
  } state_t;

  state_t               state, state_next;

  logic [8*BYTES-1:0]   mem [DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [AW:0]          count;

  logic [8*BYTES-1:0]   owr, owr_next;
  logic                 owr_valid, owr_valid_next;
  logic [IW-1:0]        byte_idx, idx_next;
  logic [7:0]           pattern, pattern_next;

  logic                 full, fifo_empty, push, pop, commit, word_done;
  logic                 pending_next;
  logic [7:0]           byte_next;

  assign wr         = state[0];
  assign fifo_level = count;

  // Handshake, commit detection and the post-edge view of the output word.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave one unassigned and infer a latch.
    full           = (count == (AW+1)'(DEPTH));
    fifo_empty     = (count == '0);
    in_ready       = reset & ~full & (MODE == 0);
    push           = in_valid & in_ready;
    commit         = ~wr & ~txe;
    word_done      = commit & (byte_idx == LAST_IDX);
    pop            = (MODE == 0) & ~fifo_empty & (~owr_valid | word_done);
    owr_next       = owr;
    owr_valid_next = owr_valid;
    idx_next       = byte_idx;
    pattern_next   = pattern + {7'd0, commit};

    if (commit) idx_next = word_done ? '0 : byte_idx + 1'b1;
    if (word_done) owr_valid_next = 1'b0;
    // Reload on the same edge the last byte leaves, so words go out back-to-back.
    if (pop) begin
      owr_next       = mem[rd_ptr];
      owr_valid_next = 1'b1;
    end

    if (MODE == 1) begin
      pending_next = 1'b1;
      byte_next    = pattern_next;
    end else begin
      pending_next = owr_valid_next;
      byte_next    = owr_next[{idx_next, 3'b000} +: 8];
    end
  end

  // Pin-level state: SEND drives WR# low, IDLE/HOLD keep it high.
  always_comb begin
    state_next = state;
    if (!pending_next)   state_next = IDLE;
    else if (!txe)       state_next = SEND;
    else if (state == IDLE) state_next = IDLE;
    else                 state_next = HOLD;
  end

  // State, output byte, counters and FIFO pointers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (!reset) begin
      state      <= IDLE;
      data_out   <= '0;
      owr        <= '0;
      owr_valid  <= 1'b0;
      byte_idx   <= '0;
      pattern    <= PATTERN_SEED;
      sent_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state     <= state_next;
      owr       <= owr_next;
      owr_valid <= owr_valid_next;
      byte_idx  <= idx_next;
      pattern   <= pattern_next;
      if (pending_next) data_out <= byte_next;
      if (commit)       sent_count <= sent_count + 32'd1;
      if (push)         wr_ptr <= wr_ptr + 1'b1;
      if (pop)          rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_ft2232h_tx_stream.sv
// Bench for ft2232h_tx_stream: a 2-byte-word stream instance (DEPTH=4) and a
// pattern-mode instance share clk/reset/txe. Queue-based reference models
// predict every output each cycle; directed phases add fixed expectations.
module tb_ft2232h_tx_stream;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        txe = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;

  logic        a_ready, a_wr;
  logic [7:0]  a_data;
  logic [2:0]  a_level;
  logic [31:0] a_sent;

  logic        p_ready, p_wr;
  logic [7:0]  p_data;
  logic [4:0]  p_level;
  logic [31:0] p_sent;

  ft2232h_tx_stream #(.DEPTH(DEPTH), .BYTES(2), .MODE(0)) dut_a (
    .clk(clk), .reset(rst), .txe(txe), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_ready), .wr(a_wr), .data_out(a_data), .fifo_level(a_level),
    .sent_count(a_sent)
  );

  ft2232h_tx_stream #(.MODE(1)) dut_p (
    .clk(clk), .reset(rst), .txe(txe), .in_data(in_data[7:0]), .in_valid(in_valid),
    .in_ready(p_ready), .wr(p_wr), .data_out(p_data), .fifo_level(p_level),
    .sent_count(p_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference models: the stream engine as a word queue feeding a byte queue,
  // the pattern engine as a plain counter.
  logic [15:0] wq[$];
  logic [7:0]  bq[$];
  logic [15:0] mw;
  logic [7:0]  mb;
  logic        ma_wr = 1'b1;
  logic [7:0]  ma_data = '0;
  logic [31:0] ma_sent = '0;
  logic        mp_wr = 1'b1;
  logic [7:0]  mp_data = '0;
  logic [7:0]  mp_pat = 8'h45;
  logic [31:0] mp_sent = '0;
  logic        acc;

  always @(posedge clk) begin
    if (!rst) begin
      wq.delete();
      bq.delete();
      ma_wr = 1'b1; ma_data = '0; ma_sent = '0;
      mp_wr = 1'b1; mp_data = '0; mp_sent = '0; mp_pat = 8'h45;
    end else begin
      acc = in_valid && (wq.size() < DEPTH);
      if (!ma_wr && !txe) begin
        mb = bq.pop_front();
        ma_sent = ma_sent + 1;
      end
      if (bq.size() == 0 && wq.size() > 0) begin
        mw = wq.pop_front();
        bq.push_back(mw[7:0]);
        bq.push_back(mw[15:8]);
      end
      if (acc) wq.push_back(in_data);
      ma_wr = !(bq.size() > 0 && !txe);
      if (bq.size() > 0) ma_data = bq[0];

      if (!mp_wr && !txe) begin
        mp_pat  = mp_pat + 8'd1;
        mp_sent = mp_sent + 1;
      end
      mp_wr   = txe;
      mp_data = mp_pat;
    end
  end

  task automatic compare_all();
    check("a_wr", 32'(a_wr), 32'(ma_wr));
    check("a_data", 32'(a_data), 32'(ma_data));
    check("a_level", 32'(a_level), 32'(wq.size()));
    check("a_sent", a_sent, ma_sent);
    check("a_ready", 32'(a_ready), 32'(rst && (wq.size() < DEPTH)));
    check("p_wr", 32'(p_wr), 32'(mp_wr));
    check("p_data", 32'(p_data), 32'(mp_data));
    check("p_sent", p_sent, mp_sent);
    check("p_ready", 32'(p_ready), 32'd0);
    check("p_level", 32'(p_level), 32'd0);
  endtask

  // Observation logs of bytes that are about to commit on the coming edge.
  logic [7:0] alog[$];
  logic [7:0] plog[$];
  logic [7:0] exp_log[$];
  int         n_acc = 0;
  int         n_low = 0;

  task automatic tick(input logic r, input logic t, input logic v, input logic [15:0] d);
    rst = r; txe = t; in_valid = v; in_data = d;
    #1;
    if (r && !a_wr && !t) alog.push_back(a_data);
    if (r && !p_wr && !t) plog.push_back(p_data);
    if (v && a_ready) n_acc++;
    if (r && !a_wr) n_low++;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic restart();
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0, 16'h0);
    alog.delete(); plog.delete(); exp_log.delete();
    n_acc = 0; n_low = 0;
  endtask

  task automatic check_log(input string tag);
    logic [31:0] got;
    check({tag, "_len"}, 32'(alog.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      got = (i < alog.size()) ? 32'(alog[i]) : 32'hFFFF_FFFF;
      check($sformatf("%s_byte%0d", tag, i), got, 32'(exp_log[i]));
    end
  endtask

  initial begin
    // Reset held with txe low and in_valid high.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 16'h5A5A);
    check("t1_wr", 32'(a_wr), 32'd1);
    check("t1_data", 32'(a_data), 32'd0);
    check("t1_ready", 32'(a_ready), 32'd0);
    check("t1_level", 32'(a_level), 32'd0);

    // Two 2-byte words, txe low: four back-to-back bytes, pattern starts at seed.
    restart();
    tick(1'b1, 1'b0, 1'b1, 16'hBEEF);
    tick(1'b1, 1'b0, 1'b1, 16'h1234);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
    exp_log = '{8'hEF, 8'hBE, 8'h34, 8'h12};
    check_log("t5");
    check("t5_wr_low_clks", 32'(n_low), 32'd4);
    check("t5_sent", a_sent, 32'd4);
    check("t5_level", 32'(a_level), 32'd0);
    check("t6_first", 32'(plog[0]), 32'h45);
    check("t6_second", 32'(plog[1]), 32'h46);
    check("t6_third", 32'(plog[2]), 32'h47);

    // txe rises right after the second byte commits; the third byte is held and re-sent once.
    restart();
    tick(1'b1, 1'b0, 1'b1, 16'h2211);
    tick(1'b1, 1'b0, 1'b1, 16'h4433);
    for (int i = 0; i < 20 && alog.size() < 2; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
    check("t3_reach", 32'(alog.size()), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b0, 16'h0);
      check("t3_hold_wr", 32'(a_wr), 32'd1);
      check("t3_hold_data", 32'(a_data), 32'h33);
    end
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
    exp_log = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_log("t3");
    check("t3_sent", a_sent, 32'd4);

    // Fill with txe high: DEPTH words in the FIFO plus one in the output word.
    restart();
    for (int k = 0; k < 7; k++)
      tick(1'b1, 1'b1, 1'b1, {8'(8'h30 + k), 8'(8'hA0 + k)});
    check("t4_accepted", 32'(n_acc), 32'd5);
    check("t4_level", 32'(a_level), 32'd4);
    check("t4_ready", 32'(a_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      exp_log.push_back(8'(8'hA0 + k));
      exp_log.push_back(8'(8'h30 + k));
    end
    // Long drain also carries the pattern counter through its 0xFF -> 0x00 wrap.
    for (int i = 0; i < 200; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
    check_log("t4");
    check("t4_sent", a_sent, 32'd10);
    check("t6_wrapped", 32'(p_sent > 32'd187), 32'd1);

    // Random traffic with txe stalls and occasional mid-burst resets.
    for (int i = 0; i < 1500; i++)
      tick(logic'($urandom_range(0, 299) != 0),
           logic'($urandom_range(0, 9) < 3),
           logic'($urandom_range(0, 9) < 6),
           16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
